// File: rtl/jstk_pkg.sv
// Shared types and defaults for the joystick conditioner: axis and fire state
// encodings, the debug struct, and the axis offset helper.
package jstk_pkg;

    // Axis encoding is chosen so bit 0 means "positive" and bit 1 means "negative".
    typedef enum logic [1:0] {
        CTR = 2'b00,
        POS = 2'b01,
        NEG = 2'b10
    } axis_state_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARMED = 2'b01,
        COOL  = 2'b10
    } fire_state_e;

    typedef struct packed {
        axis_state_e x_state;
        axis_state_e y_state;
        fire_state_e fire_state;
    } jstk_dbg_t;

    localparam int CENTER_DEF         = 512;
    localparam int DZ_ENTER_DEF       = 160;
    localparam int DZ_EXIT_DEF        = 96;
    localparam int DEBOUNCE_CYC_DEF   = 1000000;
    localparam int COOLDOWN_TICKS_DEF = 8;

    function automatic logic signed [10:0] axis_offset(input logic [9:0] pos, input int center);
        return $signed({1'b0, pos}) - $signed(11'(center));
    endfunction

endpackage

// File: rtl/joystick_conditioner_if.sv
// Front-end/engine side bundle of the joystick conditioner. The master drives the
// raw samples, tick and button; the slave (the conditioner) drives the controls.
interface joystick_conditioner_if;
    import jstk_pkg::*;

    // Inputs are level samples qualified by frame_tick; there is no ready, the
    // conditioner accepts every cycle and outputs are valid every cycle after reset.
    logic       frame_tick;
    logic [9:0] xPosData;
    logic [9:0] yPosData;
    logic       fire_btn;
    logic       move_left;
    logic       move_right;
    logic       move_up;
    logic       move_down;
    logic       fire_pulse;
    logic       btn_stable;
    jstk_dbg_t  dbg;

    modport master (
        output frame_tick, xPosData, yPosData, fire_btn,
        input  move_left, move_right, move_up, move_down, fire_pulse, btn_stable, dbg
    );

    modport slave (
        input  frame_tick, xPosData, yPosData, fire_btn,
        output move_left, move_right, move_up, move_down, fire_pulse, btn_stable, dbg
    );

endinterface

// File: rtl/axis_hysteresis.sv
// Per-axis NEG/CTR/POS tracker with an entry deadzone and a narrower exit band;
// it only re-evaluates on frame ticks.
module axis_hysteresis
    import jstk_pkg::*;
#(
    parameter int CENTER   = CENTER_DEF,
    parameter int DZ_ENTER = DZ_ENTER_DEF,
    parameter int DZ_EXIT  = DZ_EXIT_DEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        frame_tick_i,
    input  logic [9:0]  pos_i,
    output axis_state_e state_o
);

    localparam logic signed [10:0] ENTER = 11'(DZ_ENTER);
    localparam logic signed [10:0] EXIT  = 11'(DZ_EXIT);

    logic signed [10:0] d;
    axis_state_e        state_q;

    assign d = axis_offset(pos_i, CENTER);

    // A full swing past the opposite entry threshold reverses without visiting CTR.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= CTR;
        end else if (frame_tick_i) begin
            case (state_q)
                CTR: begin
                    if (d >= ENTER)       state_q <= POS;
                    else if (d <= -ENTER) state_q <= NEG;
                end
                POS: begin
                    if (d <= -ENTER)      state_q <= NEG;
                    else if (d < EXIT)    state_q <= CTR;
                end
                NEG: begin
                    if (d >= ENTER)       state_q <= POS;
                    else if (d > -EXIT)   state_q <= CTR;
                end
                default: state_q <= CTR;
            endcase
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/joystick_conditioner.sv
// Joystick conditioner: hysteretic direction flags plus a debounced, rate-limited
// fire pulse. Define AUTOFIRE_EN to repeat shots while the button stays held.
module joystick_conditioner
    import jstk_pkg::*;
#(
    parameter int CENTER         = CENTER_DEF,
    parameter int DZ_ENTER       = DZ_ENTER_DEF,
    parameter int DZ_EXIT        = DZ_EXIT_DEF,
    parameter int DEBOUNCE_CYC   = DEBOUNCE_CYC_DEF,
    parameter int COOLDOWN_TICKS = COOLDOWN_TICKS_DEF
) (
    input  logic                  clk,
    input  logic                  RST,
    joystick_conditioner_if.slave bus
);

    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int CD_W  = $clog2(COOLDOWN_TICKS + 1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    axis_state_e x_state;
    axis_state_e y_state;

    axis_hysteresis #(.CENTER(CENTER), .DZ_ENTER(DZ_ENTER), .DZ_EXIT(DZ_EXIT)) u_axis_x (
        .clk_i        (clk),
        .rst_ni       (RST),
        .frame_tick_i (bus.frame_tick),
        .pos_i        (bus.xPosData),
        .state_o      (x_state)
    );

    axis_hysteresis #(.CENTER(CENTER), .DZ_ENTER(DZ_ENTER), .DZ_EXIT(DZ_EXIT)) u_axis_y (
        .clk_i        (clk),
        .rst_ni       (RST),
        .frame_tick_i (bus.frame_tick),
        .pos_i        (bus.yPosData),
        .state_o      (y_state)
    );

    logic             sync1_q, sync2_q;
    logic             btn_stable_q, stable_prev_q;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic             db_flip;
    logic             btn_rise;

    // The counter only runs while the synchronized level disagrees with the
    // debounced level; any bounce back to agreement restarts the wait.
    always_comb begin
        db_cnt_d = '0;
        db_flip  = 1'b0;
        if (sync2_q != btn_stable_q) begin
            if (db_cnt_q == DB_LAST) db_flip = 1'b1;
            else                     db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!RST) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            db_cnt_q      <= '0;
            btn_stable_q  <= 1'b0;
            stable_prev_q <= 1'b0;
        end else begin
            sync1_q       <= bus.fire_btn;
            sync2_q       <= sync1_q;
            db_cnt_q      <= db_cnt_d;
            stable_prev_q <= btn_stable_q;
            if (db_flip) btn_stable_q <= ~btn_stable_q;
        end
    end

    assign btn_rise = btn_stable_q & ~stable_prev_q;

    fire_state_e     fire_q;
    logic [CD_W-1:0] cool_q;
    logic            fire_pulse_q;

    // A rise seen in IDLE arms; the shot waits for a later tick, so a rise and a
    // tick on the same cycle fire on the next tick.
    always_ff @(posedge clk) begin
        if (!RST) begin
            fire_q       <= IDLE;
            cool_q       <= '0;
            fire_pulse_q <= 1'b0;
        end else begin
            fire_pulse_q <= 1'b0;
            case (fire_q)
                IDLE: begin
                    if (btn_rise) fire_q <= ARMED;
                end
                ARMED: begin
                    if (bus.frame_tick) begin
                        fire_pulse_q <= 1'b1;
                        cool_q       <= CD_W'(COOLDOWN_TICKS);
                        fire_q       <= COOL;
                    end
                end
                COOL: begin
                    if (bus.frame_tick) begin
                        cool_q <= cool_q - 1'b1;
                        if (cool_q == CD_W'(1)) begin
`ifdef AUTOFIRE_EN
                            fire_q <= btn_stable_q ? ARMED : IDLE;
`else
                            fire_q <= IDLE;
`endif
                        end
                    end
                end
                default: fire_q <= IDLE;
            endcase
        end
    end

    assign bus.move_right = (x_state == POS);
    assign bus.move_left  = (x_state == NEG);
    assign bus.move_up    = (y_state == POS);
    assign bus.move_down  = (y_state == NEG);
    assign bus.fire_pulse = fire_pulse_q;
    assign bus.btn_stable = btn_stable_q;
    assign bus.dbg        = '{x_state: x_state, y_state: y_state, fire_state: fire_q};

endmodule

// File: tb/tb_joystick_conditioner.sv
// Bench for joystick_conditioner with a short debounce; an arithmetic model of the
// direction, debounce and fire rules is checked every cycle. Honours AUTOFIRE_EN.
module tb_joystick_conditioner;
    import jstk_pkg::*;

    localparam int DB = 16;
    localparam int CD = 8;
`ifdef AUTOFIRE_EN
    localparam int HOLD_PULSES = 4;
`else
    localparam int HOLD_PULSES = 1;
`endif

    logic clk = 1'b0;
    logic RST = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   pulses   = 0;

    joystick_conditioner_if jif ();

    joystick_conditioner #(.DEBOUNCE_CYC(DB), .COOLDOWN_TICKS(CD)) dut (
        .clk (clk),
        .RST (RST),
        .bus (jif)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- model ----------------
    // Axis: -1/0/+1 from the offset d and the thresholds.
    function automatic int step_axis(input int st, input int pos);
        int d;
        d = pos - 512;
        if (d >= 160) return 1;
        if (d <= -160) return -1;
        if (st == 1 && d < 96) return 0;
        if (st == -1 && d > -96) return 0;
        return st;
    endfunction

    logic [5:0] exp_q[$];
    bit         hist_q[$];
    int         ax_m, ay_m, tss_m;
    bit         stab_m, stab_prev_m, pending_m;

    // Debounced level = value the raw button held for DB samples ending 2 edges
    // ago. Fire: armed by a rise once CD ticks have passed since the last shot.
    always @(posedge clk) begin : model_b
        bit pulse_e, rise, same, v;
        pulse_e = 1'b0;
        if (!RST) begin
            ax_m = 0; ay_m = 0; tss_m = CD;
            stab_m = 1'b0; stab_prev_m = 1'b0; pending_m = 1'b0;
            hist_q.delete();
            hist_q.push_back(1'b0);
        end else begin
            rise = stab_m && !stab_prev_m;
            if (jif.frame_tick) begin
                ax_m = step_axis(ax_m, int'(jif.xPosData));
                ay_m = step_axis(ay_m, int'(jif.yPosData));
            end
            if (pending_m && jif.frame_tick) begin
                pulse_e = 1'b1; pending_m = 1'b0; tss_m = 0;
            end else if (jif.frame_tick && tss_m < CD) begin
                tss_m++;
`ifdef AUTOFIRE_EN
                if (tss_m == CD && stab_m) pending_m = 1'b1;
`endif
            end else if (rise && !pending_m && tss_m >= CD) begin
                pending_m = 1'b1;
            end
            stab_prev_m = stab_m;
            hist_q.push_back(jif.fire_btn);
            if (hist_q.size() > DB + 2) void'(hist_q.pop_front());
            if (hist_q.size() == DB + 2) begin
                v = hist_q[0];
                same = 1'b1;
                for (int j = 0; j < DB; j++) if (hist_q[j] != v) same = 1'b0;
                if (same && v != stab_m) stab_m = v;
            end
        end
        exp_q.push_back({ax_m == -1, ax_m == 1, ay_m == 1, ay_m == -1, pulse_e, stab_m});
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        logic [5:0] e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {jif.move_left, jif.move_right, jif.move_up, jif.move_down,
                 jif.fire_pulse, jif.btn_stable};
            chk("cycle_lrudfs", 32'(a), 32'(e));
            if (jif.fire_pulse === 1'b1) pulses++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clks(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Returns 2 time units after the edge that sampled the tick.
    task automatic tick();
        @(posedge clk);
        #2 jif.frame_tick = 1'b1;
        @(posedge clk);
        #2 jif.frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick();
            clks(3);
        end
    endtask

    task automatic x_tick(input int x, input string name, input logic l, input logic r);
        jif.xPosData = 10'(x);
        tick();
        chk({name, "_left"}, 32'(jif.move_left), 32'(l));
        chk({name, "_right"}, 32'(jif.move_right), 32'(r));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int p0;
        jif.frame_tick = 1'b0;
        jif.xPosData   = 10'd512;
        jif.yPosData   = 10'd512;
        jif.fire_btn   = 1'b0;

        // Reset with X pushed hard and the button held.
        jif.xPosData = 10'd900;
        jif.fire_btn = 1'b1;
        clks(1);
        tick();
        clks(1);
        chk("rst_right", 32'(jif.move_right), 32'd0);
        chk("rst_stable", 32'(jif.btn_stable), 32'd0);
        chk("rst_pulse", 32'(jif.fire_pulse), 32'd0);
        RST = 1'b1;
        clks(5);
        chk("db_not_yet", 32'(jif.btn_stable), 32'd0);
        clks(25);
        chk("db_done", 32'(jif.btn_stable), 32'd1);
        chk("no_pulse_before_tick", 32'(jif.fire_pulse), 32'd0);
        tick();
        chk("first_shot", 32'(jif.fire_pulse), 32'd1);
        chk("right_after_rst", 32'(jif.move_right), 32'd1);
        clks(1);
        chk("shot_one_wide", 32'(jif.fire_pulse), 32'd0);
        jif.fire_btn = 1'b0;
        clks(25);

        // Hysteresis and thresholds on X.
        x_tick(512, "x512", 1'b0, 1'b0);
        x_tick(680, "x680", 1'b0, 1'b1);
        x_tick(615, "x615", 1'b0, 1'b1);
        x_tick(600, "x600", 1'b0, 1'b0);
        x_tick(672, "x672", 1'b0, 1'b1);
        x_tick(608, "x608", 1'b0, 1'b1);
        x_tick(607, "x607", 1'b0, 1'b0);
        x_tick(352, "x352", 1'b1, 1'b0);
        x_tick(416, "x416", 1'b1, 1'b0);
        x_tick(417, "x417", 1'b0, 1'b0);
        x_tick(0, "x0", 1'b1, 1'b0);
        x_tick(1023, "x1023", 1'b0, 1'b1);
        x_tick(512, "xback", 1'b0, 1'b0);

        // Direct reversal on Y and samples between ticks ignored.
        jif.yPosData = 10'd700;
        tick();
        chk("y700_up", 32'(jif.move_up), 32'd1);
        jif.yPosData = 10'd300;
        tick();
        chk("y300_down", 32'(jif.move_down), 32'd1);
        chk("y300_up", 32'(jif.move_up), 32'd0);
        jif.yPosData = 10'd512;
        clks(5);
        chk("y_no_tick_hold", 32'(jif.move_down), 32'd1);
        tick();
        chk("y512_down", 32'(jif.move_down), 32'd0);

        // Bouncing button never settles.
        p0 = pulses;
        for (int i = 0; i < 30; i++) begin
            jif.fire_btn = ~jif.fire_btn;
            clks(10);
            if (i % 5 == 0) tick();
        end
        jif.fire_btn = 1'b0;
        clks(25);
        chk("bounce_stable", 32'(jif.btn_stable), 32'd0);
        chk("bounce_pulses", 32'(pulses - p0), 32'd0);

        // Release while armed still fires; presses during cooldown are dropped.
        p0 = pulses;
        jif.fire_btn = 1'b1;
        clks(25);
        jif.fire_btn = 1'b0;
        clks(25);
        tick();
        chk("armed_release_fires", 32'(jif.fire_pulse), 32'd1);
        ticks(3);
        jif.fire_btn = 1'b1;
        clks(25);
        jif.fire_btn = 1'b0;
        clks(25);
        ticks(6);
        chk("cool_press_dropped", 32'(pulses - p0), 32'd1);
        jif.fire_btn = 1'b1;
        clks(25);
        jif.fire_btn = 1'b0;
        clks(25);
        tick();
        chk("after_cool_fires", 32'(jif.fire_pulse), 32'd1);

        // Held button across 30 ticks.
        ticks(9);
        p0 = pulses;
        jif.fire_btn = 1'b1;
        clks(25);
        ticks(30);
        jif.fire_btn = 1'b0;
        clks(25);
        chk("hold_pulses", 32'(pulses - p0), 32'(HOLD_PULSES));

        // Reset aborts debounce, an armed shot, and a cooldown.
        ticks(9);
        jif.fire_btn = 1'b1;
        clks(10);
        RST = 1'b0;
        jif.fire_btn = 1'b0;
        clks(2);
        RST = 1'b1;
        clks(30);
        chk("rst_mid_debounce", 32'(jif.btn_stable), 32'd0);
        jif.fire_btn = 1'b1;
        clks(25);
        jif.fire_btn = 1'b0;
        RST = 1'b0;
        clks(2);
        RST = 1'b1;
        clks(25);
        tick();
        chk("rst_armed_no_shot", 32'(jif.fire_pulse), 32'd0);
        jif.fire_btn = 1'b1;
        clks(25);
        tick();
        chk("shot_before_rst", 32'(jif.fire_pulse), 32'd1);
        jif.fire_btn = 1'b0;
        clks(25);
        RST = 1'b0;
        clks(2);
        RST = 1'b1;
        jif.fire_btn = 1'b1;
        clks(25);
        tick();
        chk("rst_clears_cool", 32'(jif.fire_pulse), 32'd1);
        jif.fire_btn = 1'b0;
        clks(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/joystick_conditioner.md
Name: joystick_conditioner

Overview:
- Sits between the PmodJSTK_Demo joystick front end and the game engine.
- Converts raw 10-bit joystick X/Y samples and a raw fire button into clean per-frame controls for the engine:
  - registered direction flags with deadzone and hysteresis;
  - a debounced, rate-limited, single-cycle fire pulse.
- Everything runs on the 100 MHz master clock. Frame cadence comes from a single-cycle frame_tick strobe derived from clockdiv's 30 Hz output.

Parameters:
CENTER, 512, nominal joystick rest value on both axes
DZ_ENTER, 160, offset from CENTER needed to enter a direction
DZ_EXIT, 96, offset from CENTER below which a direction is released (must be < DZ_ENTER)
DEBOUNCE_CYC, 1000000, clk cycles the synchronized button must be stable (10 ms)
COOLDOWN_TICKS, 8, frame ticks after a shot before another fire pulse is allowed

Ports:
clk  in  1  master clock, 100 MHz
RST  in  1  reset; synchronous, active-low
frame_tick  in  1  one-cycle strobe, once per game frame (30 Hz)
xPosData  in  10  raw joystick X sample, 0..1023
yPosData  in  10  raw joystick Y sample, 0..1023
fire_btn  in  1  raw, asynchronous fire button
move_left  out  1  X held left
move_right  out  1  X held right
move_up  out  1  Y held up
move_down  out  1  Y held down
fire_pulse  out  1  one-cycle shot request
btn_stable  out  1  debounced button level (debug/LED)

Behaviour:
- Reset: sampled when RST==0 at a clk edge. On reset:
  - all outputs go to 0;
  - both axis FSMs go to CTR;
  - the fire FSM goes to IDLE;
  - all counters clear;
  - the synchronizer flops clear.
  A reset that arrives mid-debounce or mid-cooldown aborts the operation, and no pulse follows.
- Axis arithmetic:
  - d = signed 11-bit (pos - CENTER), computed with no wrap; valid range is -512..+511.
  - Thresholds are compared with >= / <= against ±DZ_ENTER and ±DZ_EXIT.
- Axis FSM, one per axis, with states NEG, CTR and POS. It evaluates only on cycles where frame_tick==1.
  - CTR -> POS if d >= DZ_ENTER.
  - CTR -> NEG if d <= -DZ_ENTER.
  - POS -> CTR if d < DZ_EXIT. POS -> NEG directly if d <= -DZ_ENTER.
  - NEG -> CTR if d > -DZ_EXIT. NEG -> POS directly if d >= DZ_ENTER.
  - Otherwise the state holds.
- Direction outputs:
  - X: move_right = (state==POS), move_left = (state==NEG).
  - Y: move_up = (state==POS), move_down = (state==NEG).
  - Outputs are registered and change exactly 1 clk after the tick edge.
  - Left and right are never asserted together; up and down are never asserted together.
  - Samples arriving between ticks are ignored.
- Button path:
  - 2-FF synchronizer feeds the debouncer.
  - The counter resets whenever the synchronized level differs from btn_stable.
  - btn_stable flips when the counter reaches DEBOUNCE_CYC-1.
- Fire FSM, with states IDLE, ARMED and COOL:
  - IDLE: a rising edge of btn_stable moves to ARMED.
  - ARMED: on the next frame_tick, fire_pulse=1 for exactly 1 clk (the cycle after the tick), load the cooldown counter with COOLDOWN_TICKS, and go to COOL.
  - COOL: decrement the counter on each frame_tick. At 0, go to IDLE.
  - Rising edges of btn_stable during COOL are dropped (no queueing).
  - A press and a tick on the same cycle: the edge registers first and fires on the following tick, not the current one.
  - Button release while ARMED does not cancel the shot.
- Latency:
  - Direction output: 1 clk after the tick.
  - Fire: debounce time, plus wait to the next tick, plus 1 clk.

Optional Feature:
Macro AUTOFIRE_EN.
- When defined: if btn_stable stays 1 when COOL expires, the FSM goes straight to ARMED, giving repeat shots every COOLDOWN_TICKS+1 ticks while the button is held.
- When undefined: each shot requires a new press (release then press).

Decomposition:
- Shared package jstk_pkg holds:
  - the axis state encoding (NEG=2'b10, CTR=2'b00, POS=2'b01);
  - the fire state encoding;
  - default constants for CENTER and the thresholds.
- One sub-module, axis_hysteresis, is instantiated twice for X and Y. It takes pos and frame_tick and returns the 2-bit state.
- The debouncer and fire FSM stay inline.

Test Plan:
- Reset: hold RST=0 for 3 clks with xPos=900 and the button held -> all outputs stay 0; after release, fire_pulse does not fire until the debounce completes and a tick arrives.
- Hysteresis: xPos=680 then tick -> move_right=1 one clk after the tick. xPos=615 then tick -> stays 1. xPos=600 then tick -> move_right=0.
- Direct reversal: yPos=700 then tick -> up=1. yPos=300 then tick -> down=1 and up=0 on the same cycle.
- Debounce: toggle fire_btn every 1000 clks for 50k clks -> btn_stable stays 0 and no fire_pulse. Hold it high for 1.01M clks, then tick -> one fire_pulse, 1 clk wide.
- Cooldown: a second press 3 ticks after a shot -> no pulse. A press after 9 ticks -> pulse.
- AUTOFIRE_EN: hold the button for 30 ticks -> pulses 9 ticks apart. Without the macro -> exactly 1 pulse.
